// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared types and trigger-config bit positions for the logic-analyzer capture controller
package la_pkg;

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} cap_state_t;

  localparam int TRIG_RISE = 4;
  localparam int TRIG_FALL = 3;
  localparam int TRIG_HIGH = 2;
  localparam int TRIG_LOW  = 1;
  localparam int TRIG_DC   = 0;

endpackage

// File: rtl/la_capture_ctrl_if.sv
// rtl/la_capture_ctrl_if.sv - command/status and RAM write bus between command logic and capture controller
interface la_capture_ctrl_if #(parameter int LOG2 = 9);

  logic            start;
  logic            stop;
  logic            clr_done;
  logic            continuous;
  logic [LOG2-1:0] trig_pos;
  logic            we;
  logic [LOG2-1:0] waddr;
  logic            armed;
  logic            triggered;
  logic            capture_done;
  logic [LOG2-1:0] rd_start_addr;

  modport master (
    output start, stop, clr_done, continuous, trig_pos,
    input  we, waddr, armed, triggered, capture_done, rd_start_addr
  );

  modport slave (
    input  start, stop, clr_done, continuous, trig_pos,
    output we, waddr, armed, triggered, capture_done, rd_start_addr
  );

endinterface

// File: rtl/la_chan_trig.sv
// rtl/la_chan_trig.sv - single-channel level/edge trigger evaluation with its own previous-high flop
module la_chan_trig
  import la_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hi,
  input  logic       lo,
  input  logic [4:0] cfg,
  output logic       trig
);

  logic hi_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hi_prev <= 1'b0;
    else     hi_prev <= hi;
  end

  assign trig = cfg[TRIG_DC]
              | (cfg[TRIG_RISE] & ~hi_prev &  hi)
              | (cfg[TRIG_FALL] &  hi_prev & ~hi)
              | (cfg[TRIG_HIGH] &  hi)
              | (cfg[TRIG_LOW]  & ~lo);

endmodule

// File: rtl/la_capture_ctrl.sv
// rtl/la_capture_ctrl.sv - circular-RAM capture/trigger sequencer over NUM_CH channels
// Optional LA_TRIG_HOLDOFF_EN adds trig_holdoff, masking the trigger for N clocks after arming.
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int NUM_CH  = 5,
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrt_smpl,
  input  logic [NUM_CH-1:0]   ch_hi,
  input  logic [NUM_CH-1:0]   ch_lo,
  input  logic [5*NUM_CH-1:0] ch_trig_cfg,
  input  logic                prot_trig,
  input  logic                prot_trig_dis,
`ifdef LA_TRIG_HOLDOFF_EN
  input  logic [15:0]         trig_holdoff,
`endif
  la_capture_ctrl_if.slave    bus
);

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  cap_state_t      state, state_nxt;
  logic [NUM_CH-1:0] ch_trig;
  logic            trig_all, trig_q, arm_q, hold_ok, trig_ok, we, restart;
  logic [LOG2-1:0] tp, waddr, waddr_inc, post_cnt, rd_addr;
  logic [LOG2:0]   smpl_cnt, pre_len;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    la_chan_trig u_chan_trig (
      .clk  (clk),
      .rst  (rst),
      .hi   (ch_hi[i]),
      .lo   (ch_lo[i]),
      .cfg  (ch_trig_cfg[5*i +: 5]),
      .trig (ch_trig[i])
    );
  end

  assign trig_all  = (&ch_trig) & (prot_trig | prot_trig_dis);
  assign we        = wrt_smpl & (state inside {PRE, ARMED, POST});
  assign waddr_inc = (waddr == LAST) ? '0 : waddr + LOG2'(1);
  assign pre_len   = (LOG2+1)'(ENTRIES) - {1'b0, tp};
  assign restart   = bus.start & ~bus.stop;

`ifdef LA_TRIG_HOLDOFF_EN
  logic [15:0] hold_cnt;
  assign hold_ok = (hold_cnt == 16'd0);
`else
  assign hold_ok = 1'b1;
`endif

  // arm_q drops the registered trigger from the arming edge itself
  assign trig_ok = trig_q & arm_q & hold_ok;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = IDLE;
      PRE:   if (we && (smpl_cnt + (LOG2+1)'(1) == pre_len)) state_nxt = ARMED;
      ARMED: if (trig_ok) state_nxt = POST;
      POST:  if ((tp == '0) || (we && (post_cnt + LOG2'(1) == tp))) state_nxt = DONE;
      DONE:  if (bus.clr_done) state_nxt = bus.continuous ? PRE : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.start) state_nxt = PRE;
    if (bus.stop)  state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      trig_q   <= 1'b0;
      arm_q    <= 1'b0;
      tp       <= '0;
      waddr    <= '0;
      smpl_cnt <= '0;
      post_cnt <= '0;
      rd_addr  <= '0;
    end else begin
      state  <= state_nxt;
      trig_q <= trig_all;
      arm_q  <= (state == ARMED);
      if (restart) tp <= (bus.trig_pos >= LAST) ? LAST : bus.trig_pos;
      if (we) waddr <= waddr_inc;
      if (restart) waddr <= '0;
      if (state_nxt == PRE && (state != PRE || restart)) smpl_cnt <= '0;
      else if (state == PRE && we)                        smpl_cnt <= smpl_cnt + (LOG2+1)'(1);
      if (state != POST) post_cnt <= '0;
      else if (we)       post_cnt <= post_cnt + LOG2'(1);
      // next write slot is the oldest sample once the ring has been filled
      if (state == POST && state_nxt == DONE) rd_addr <= we ? waddr_inc : waddr;
    end
  end

`ifdef LA_TRIG_HOLDOFF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        hold_cnt <= 16'd0;
    else if (state_nxt == ARMED && state != ARMED)  hold_cnt <= trig_holdoff;
    else if (state == ARMED && hold_cnt != 16'd0)   hold_cnt <= hold_cnt - 16'd1;
  end
`endif

  assign bus.we            = we;
  assign bus.waddr         = waddr;
  assign bus.armed         = (state == ARMED);
  assign bus.triggered     = (state == POST);
  assign bus.capture_done  = (state == DONE);
  assign bus.rd_start_addr = rd_addr;

endmodule
